// File: rtl/jtdd_sync_recover_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtdd_sync_recover_pkg: shared FSM states, sync-signal indices and the
// nominal video timing of the companion timing generator.
// Rev 1.0
// ----------------------------------------------------------------------------
package jtdd_sync_recover_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int SIG_HS  = 0;
  localparam int SIG_VS  = 1;
  localparam int SIG_HBL = 2;
  localparam int SIG_VBL = 3;
  localparam int NSIG    = 4;

  localparam int JTDD_HTOTAL  = 384;
  localparam int JTDD_HACTIVE = 256;
  localparam int JTDD_VTOTAL  = 272;
  localparam int JTDD_VACTIVE = 240;

endpackage
`default_nettype wire

// File: rtl/jtdd_edge_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtdd_edge_det: pixel-enable sampled history of one sync input plus
// rise/fall strobes, valid only during the enabled cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
module jtdd_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pxl_cen_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else if (pxl_cen_i) begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = pxl_cen_i &  sig_i & ~sig_q;
  assign fall_o = pxl_cen_i & ~sig_i &  sig_q;

endmodule
`default_nettype wire

// File: rtl/jtdd_sync_recover.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtdd_sync_recover: rebuilds pixel/line counters from HS/VS/HBL/VBL,
// measures line/frame geometry and flags lock once the timing is stable.
// Rev 1.0
// ----------------------------------------------------------------------------
module jtdd_sync_recover
  import jtdd_sync_recover_pkg::*;
#(
  parameter int HW          = 9,
  parameter int VW          = 9,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          HS,
  input  logic          VS,
  input  logic          HBL,
  input  logic          VBL,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] htotal,
  output logic [HW-1:0] hactive,
  output logic [HW-1:0] hs_pos,
  output logic [VW-1:0] vtotal,
  output logic [VW-1:0] vactive,
  output logic          line_start,
  output logic          frame_start,
  output logic          locked
);

  localparam int            FW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [HW-1:0] HMAX    = '1;
  localparam logic [VW-1:0] VMAX    = '1;
  localparam logic [FW-1:0] OK_LAST = FW'(LOCK_FRAMES - 1);

  logic [NSIG-1:0] sync_vec, rise, fall;
  logic            unused_edges;

  assign sync_vec = {VBL, HBL, VS, HS};

  for (genvar i = 0; i < NSIG; i++) begin : g_edge
    jtdd_edge_det u_det (
      .clk       (clk),
      .rst       (rst),
      .pxl_cen_i (pxl_cen),
      .sig_i     (sync_vec[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i])
    );
  end

  assign unused_edges = ^{rise[SIG_VS], rise[SIG_HBL], rise[SIG_VBL],
                          fall[SIG_HS], fall[SIG_VS], fall[SIG_VBL]};

  logic [HW-1:0] hcnt_q, hcnt_d, htotal_q, htotal_d, hactive_q, hactive_d;
  logic [HW-1:0] hs_pos_q, hs_pos_d, cur_act_q, cur_act_d, snap_h_q, snap_h_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vtotal_q, vtotal_d, vactive_q, vactive_d;
  logic [VW-1:0] cur_vact_q, cur_vact_d, snap_v_q, snap_v_d;
  logic [FW-1:0] frame_ok_q, frame_ok_d;
  logic          vbl_at_ls_q, vbl_at_ls_d, ls_q, ls_d, fs_q, fs_d;
  state_e        state_q, state_d;

  logic          ls, fs, hs_rise, h_sat, v_sat, same_frame;
  logic [HW-1:0] h_inc;
  logic [VW-1:0] v_inc;

  assign ls         = fall[SIG_HBL];
  assign fs         = ls & ~VBL & vbl_at_ls_q;
  assign hs_rise    = rise[SIG_HS];
  assign h_inc      = hcnt_q + 1'b1;
  assign v_inc      = vcnt_q + 1'b1;
  assign h_sat      = pxl_cen & ~ls & (hcnt_q == HMAX);
  assign v_sat      = ls & ~fs & (vcnt_q == VMAX);
  assign same_frame = (h_inc == snap_h_q) && (v_inc == snap_v_q);

  always_comb begin
    hcnt_d      = hcnt_q;
    htotal_d    = htotal_q;
    hactive_d   = hactive_q;
    hs_pos_d    = hs_pos_q;
    cur_act_d   = cur_act_q;
    vcnt_d      = vcnt_q;
    vtotal_d    = vtotal_q;
    vactive_d   = vactive_q;
    cur_vact_d  = cur_vact_q;
    vbl_at_ls_d = vbl_at_ls_q;
    ls_d        = 1'b0;
    fs_d        = 1'b0;
    if (pxl_cen) begin
      if (ls) begin
        hcnt_d    = '0;
        htotal_d  = h_inc;
        hactive_d = cur_act_q;
        cur_act_d = HW'(1);
      end else begin
        if (hcnt_q != HMAX) hcnt_d = h_inc;
        if (!HBL && cur_act_q != HMAX) cur_act_d = cur_act_q + 1'b1;
      end
      // HS rising on the line-start pixel lands at column 0
      if (hs_rise) hs_pos_d = ls ? '0 : h_inc;
      if (ls) begin
        ls_d        = 1'b1;
        fs_d        = fs;
        vbl_at_ls_d = VBL;
        if (fs) begin
          vcnt_d     = '0;
          vtotal_d   = v_inc;
          vactive_d  = cur_vact_q;
          cur_vact_d = VW'(1);
        end else begin
          if (vcnt_q != VMAX) vcnt_d = v_inc;
          if (!VBL && cur_vact_q != VMAX) cur_vact_d = cur_vact_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_ok_d = frame_ok_q;
    snap_h_d   = snap_h_q;
    snap_v_d   = snap_v_q;
    if (fs) begin
      snap_h_d = h_inc;
      snap_v_d = v_inc;
    end
    case (state_q)
      SEARCH: begin
        if (fs) begin
          state_d    = MEASURE;
          frame_ok_d = '0;
        end
      end
      MEASURE: begin
        if (fs) begin
          if (!same_frame)              frame_ok_d = '0;
          else if (frame_ok_q == OK_LAST) state_d  = LOCKED;
          else                          frame_ok_d = frame_ok_q + 1'b1;
        end
      end
      LOCKED: begin
        if ((ls && h_inc != htotal_q) || (fs && v_inc != vtotal_q) || h_sat || v_sat) begin
          state_d    = SEARCH;
          frame_ok_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= '0;
      htotal_q    <= '0;
      hactive_q   <= '0;
      hs_pos_q    <= '0;
      cur_act_q   <= '0;
      vcnt_q      <= '0;
      vtotal_q    <= '0;
      vactive_q   <= '0;
      cur_vact_q  <= '0;
      vbl_at_ls_q <= 1'b0;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
      state_q     <= SEARCH;
      frame_ok_q  <= '0;
      snap_h_q    <= '0;
      snap_v_q    <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      htotal_q    <= htotal_d;
      hactive_q   <= hactive_d;
      hs_pos_q    <= hs_pos_d;
      cur_act_q   <= cur_act_d;
      vcnt_q      <= vcnt_d;
      vtotal_q    <= vtotal_d;
      vactive_q   <= vactive_d;
      cur_vact_q  <= cur_vact_d;
      vbl_at_ls_q <= vbl_at_ls_d;
      ls_q        <= ls_d;
      fs_q        <= fs_d;
      state_q     <= state_d;
      frame_ok_q  <= frame_ok_d;
      snap_h_q    <= snap_h_d;
      snap_v_q    <= snap_v_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign htotal      = htotal_q;
  assign hactive     = hactive_q;
  assign hs_pos      = hs_pos_q;
  assign vtotal      = vtotal_q;
  assign vactive     = vactive_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_jtdd_sync_recover.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_jtdd_sync_recover: directed bench with a small synthetic video timing
// (20 px/line, 12 active, HS at 15; 10 lines/frame, 6 active, VS at line 7).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_jtdd_sync_recover;

  localparam int HT  = 20;
  localparam int HA  = 12;
  localparam int HSS = 15;
  localparam int VT  = 10;
  localparam int VA  = 6;
  localparam int VSS = 7;

  logic clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0;
  logic HS = 1'b0, VS = 1'b0, HBL = 1'b0, VBL = 1'b0;

  logic [8:0] hcnt, vcnt, htotal, hactive, hs_pos, vtotal, vactive;
  logic       line_start, frame_start, locked;
  logic [8:0] hcnt1, vcnt1, htotal1, hactive1, hs_pos1, vtotal1, vactive1;
  logic       line_start1, frame_start1, locked1;

  int n_vec = 0, n_err = 0, ls_cnt = 0, fs_cnt = 0, cen_per = 4;
  int ls0, fs0;

  jtdd_sync_recover #(.HW(9), .VW(9), .LOCK_FRAMES(2)) u_dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .HS(HS), .VS(VS), .HBL(HBL), .VBL(VBL),
    .hcnt(hcnt), .vcnt(vcnt), .htotal(htotal), .hactive(hactive),
    .hs_pos(hs_pos), .vtotal(vtotal), .vactive(vactive),
    .line_start(line_start), .frame_start(frame_start), .locked(locked)
  );

  jtdd_sync_recover #(.HW(9), .VW(9), .LOCK_FRAMES(1)) u_dut1 (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .HS(HS), .VS(VS), .HBL(HBL), .VBL(VBL),
    .hcnt(hcnt1), .vcnt(vcnt1), .htotal(htotal1), .hactive(hactive1),
    .hs_pos(hs_pos1), .vtotal(vtotal1), .vactive(vactive1),
    .line_start(line_start1), .frame_start(frame_start1), .locked(locked1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel: inputs held for cen_per clocks, pxl_cen high on the last one.
  task automatic pixel(input logic hbl, input logic hs, input logic vbl, input logic vs);
    HBL = hbl; HS = hs; VBL = vbl; VS = vs;
    repeat (cen_per - 1) begin
      pxl_cen = 1'b0;
      @(posedge clk); #1;
    end
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
  endtask

  task automatic do_line(input int y, input int xend, input int x0);
    for (int x = x0; x < xend; x++)
      pixel(x >= HA, (x >= HSS) && (x < HSS + 2), y >= VA, y == VSS);
  endtask

  task automatic do_frame(input int vt, input int stretch);
    for (int y = 0; y < vt; y++)
      do_line(y, (y == stretch) ? HT + 1 : HT, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {hcnt, vcnt, htotal, hactive, hs_pos, vtotal, vactive,
                          line_start, frame_start, locked, locked1}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal timing, pixel enable 1-in-4
    cen_per = 4;
    for (int f = 0; f < 4; f++) do_frame(VT, -1);
    chk("t1_hcnt",    hcnt,    19);
    chk("t1_vcnt",    vcnt,    9);
    chk("t1_htotal",  htotal,  HT);
    chk("t1_hactive", hactive, HA);
    chk("t1_hs_pos",  hs_pos,  HSS);
    chk("t1_vtotal",  vtotal,  VT);
    chk("t1_vactive", vactive, VA);
    chk("t1_locked",  locked,  1);
    chk("t1_locked1", locked1, 1);
    chk("t1_ls_cnt",  ls_cnt,  9 + 3 * VT);
    chk("t1_fs_cnt",  fs_cnt,  3);

    // One stretched line drops lock at the next line start
    cen_per = 1;
    for (int y = 0; y < 4; y++) do_line(y, (y == 3) ? HT + 1 : HT, 0);
    pixel(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_drop_locked",  locked,     0);
    chk("t2_drop_locked1", locked1,    0);
    chk("t2_htotal",       htotal,     HT + 1);
    chk("t2_line_start",   line_start, 1);
    do_line(4, HT, 1);
    for (int y = 5; y < VT; y++) do_line(y, HT, 0);
    do_frame(VT, -1);
    do_frame(VT, -1);
    chk("t2_wait_locked",  locked,  0);
    chk("t2_relock1",      locked1, 1);
    do_frame(VT, -1);
    chk("t2_relock",       locked,  1);

    // HBL held low for 600 pixels
    ls0 = ls_cnt;
    pixel(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_frame_start", frame_start, 1);
    repeat (599) pixel(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_hcnt_sat",  hcnt,          511);
    chk("t3_locked",    locked,        0);
    chk("t3_no_ls",     ls_cnt - ls0,  1);
    do_line(0, HT, HA);
    do_line(1, HT, 0);
    chk("t3_hactive_sat", hactive, 511);
    chk("t3_htotal_wrap", htotal,  (511 + 1) % 512);
    for (int y = 2; y < VT; y++) do_line(y, HT, 0);

    // Asynchronous reset mid-frame
    cen_per = 2;
    for (int y = 0; y < 3; y++) do_line(y, HT, 0);
    do_line(3, 6, 0);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_reset", {hcnt, vcnt, htotal, hactive, hs_pos, vtotal, vactive,
                           line_start, frame_start, locked, locked1}, '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_line(3, HT, 6);
    for (int y = 4; y < VT; y++) do_line(y, HT, 0);
    for (int f = 0; f < 3; f++) do_frame(VT, -1);
    chk("t4_partial_locked", locked,  0);
    chk("t4_relock1",        locked1, 1);
    do_frame(VT, -1);
    chk("t4_relock",  locked, 1);
    chk("t4_vtotal",  vtotal, VT);

    // Pixel enable stalled for 1000 clocks mid-line while inputs wiggle
    cen_per = 1;
    for (int y = 0; y < 5; y++) do_line(y, HT, 0);
    do_line(5, 8, 0);
    ls0 = ls_cnt;
    pxl_cen = 1'b0;
    HBL = 1'b1; HS = 1'b1;
    repeat (500) @(posedge clk);
    HBL = 1'b0; HS = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("t5_hcnt",   hcnt,         7);
    chk("t5_vcnt",   vcnt,         5);
    chk("t5_locked", locked,       1);
    chk("t5_no_ls",  ls_cnt - ls0, 0);
    chk("t5_hs_pos", hs_pos,       HSS);
    do_line(5, HT, 8);
    for (int y = 6; y < VT; y++) do_line(y, HT, 0);
    do_frame(VT, -1);
    chk("t5_locked_after", locked,  1);
    chk("t5_htotal",       htotal,  HT);
    chk("t5_hactive",      hactive, HA);

    // Frame height alternating 11/10 lines
    fs0 = fs_cnt;
    do_frame(VT + 1, -1);
    do_frame(VT, -1);
    chk("t6_drop_locked1", locked1, 0);
    do_frame(VT + 1, -1);
    chk("t6_c_locked1", locked1, 0);
    do_frame(VT, -1);
    chk("t6_d_locked1", locked1, 0);
    do_frame(VT + 1, -1);
    chk("t6_e_locked1", locked1, 0);
    chk("t6_e_locked",  locked,  0);
    chk("t6_vtotal",    vtotal,  VT);
    chk("t6_fs_cnt",    fs_cnt - fs0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
